dds_sweep_sequencer: RTL and testbench

//   Frequency-sweep scheduler for one DDS voice. Sits between the SPI command decoder and the

---
 rtl/dds_sweep_pkg.sv | 23 ++
 rtl/dds_sweep_sequencer_if.sv | 25 ++
 rtl/sweep_dwell_timer.sv | 26 ++
 rtl/dds_sweep_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_dds_sweep_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_sweep_pkg.sv
// Shared types and constants for the DDS sweep sequencer: FSM states, sweep modes
// and configuration register addresses.
package dds_sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DWELL,
    S_STEP,
    S_DONE
  } sweep_state_t;

  localparam logic [1:0] SWEEP_SINGLE   = 2'b00;
  localparam logic [1:0] SWEEP_REPEAT   = 2'b01;
  localparam logic [1:0] SWEEP_PINGPONG = 2'b10;

  localparam int unsigned SWEEP_REG_START = 0;
  localparam int unsigned SWEEP_REG_STOP  = 1;
  localparam int unsigned SWEEP_REG_STEP  = 2;
  localparam int unsigned SWEEP_REG_DWELL = 3;
  localparam int unsigned SWEEP_REG_CTRL  = 4;

endpackage

// File: rtl/dds_sweep_sequencer_if.sv
// Config/strobe inputs and tuning outputs of the DDS sweep sequencer.
// master drives config and tick; slave is the sequencer.
interface dds_sweep_sequencer_if #(
  parameter int TUNE_W = 16,
  parameter int ADDR_W = 3
);
  logic              tick;
  logic              cfg_wr;
  logic [ADDR_W-1:0] cfg_addr;
  logic [TUNE_W-1:0] cfg_data;
  logic [TUNE_W-1:0] tune_out;
  logic              tune_valid;
  logic              busy;
  logic              done;

  modport master (
    output tick, cfg_wr, cfg_addr, cfg_data,
    input  tune_out, tune_valid, busy, done
  );

  modport slave (
    input  tick, cfg_wr, cfg_addr, cfg_data,
    output tune_out, tune_valid, busy, done
  );
endinterface

// File: rtl/sweep_dwell_timer.sv
// Loadable dwell down-counter; expire flags the tick that consumes the last dwell count.
module sweep_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick_en,
  output logic         expire
);
  logic [W-1:0] cnt_q, cnt_d;

  assign expire = tick_en && (cnt_q == W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (load)         cnt_d = load_val;
    else if (tick_en) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/dds_sweep_sequencer.sv
// DDS sweep scheduler: steps the tuning word START->STOP by STEP, holding each for DWELL ticks.
// Define DDS_SWEEP_PINGPONG_EN to build ping-pong mode; otherwise mode 10 runs as single.
module dds_sweep_sequencer
  import dds_sweep_pkg::*;
#(
  parameter int TUNE_W  = 16,
  parameter int DWELL_W = 16,
  parameter int ADDR_W  = 3
) (
  input logic                  sys_clk,
  input logic                  rst,
  dds_sweep_sequencer_if.slave bus
);
  sweep_state_t      state_q, state_d;
  logic [TUNE_W-1:0] reg_start_q, reg_start_d, reg_stop_q, reg_stop_d, reg_step_q, reg_step_d;
  logic [DWELL_W-1:0] reg_dwell_q, reg_dwell_d;
  logic [1:0]        reg_mode_q, reg_mode_d;
  logic [TUNE_W-1:0] tune_q, tune_d;
  logic              tune_valid_q, tune_valid_d, busy_q, busy_d, done_q, done_d;
  logic [TUNE_W-1:0] tgt_q, tgt_d, step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d, dwell_eff;
  logic              dir_q, dir_d;
`ifdef DDS_SWEEP_PINGPONG_EN
  logic [TUNE_W-1:0] org_q, org_d;
`endif
  logic              ctrl_wr, tmr_load, tmr_en, tmr_expire;
  logic [DWELL_W-1:0] tmr_val;
  logic [1:0]        mode;
  logic [TUNE_W:0]   step_res;

  function automatic logic [1:0] decode_mode(input logic [1:0] m);
`ifdef DDS_SWEEP_PINGPONG_EN
    if (m == SWEEP_REPEAT || m == SWEEP_PINGPONG) return m;
    return SWEEP_SINGLE;
`else
    return (m == SWEEP_REPEAT) ? SWEEP_REPEAT : SWEEP_SINGLE;
`endif
  endfunction

  // Returns {endpoint_hit, next_word}; the extra bit keeps overshoot from wrapping.
  function automatic logic [TUNE_W:0] step_clamp(input logic [TUNE_W-1:0] cur,
                                                 input logic [TUNE_W-1:0] stp,
                                                 input logic [TUNE_W-1:0] tgt,
                                                 input logic              up);
    logic [TUNE_W:0] nxt;
    logic            hit;
    if (up) begin
      nxt = {1'b0, cur} + {1'b0, stp};
      hit = (nxt >= {1'b0, tgt});
    end else begin
      nxt = {1'b0, cur} - {1'b0, stp};
      hit = nxt[TUNE_W] || (nxt <= {1'b0, tgt});
    end
    return hit ? {1'b1, tgt} : {1'b0, nxt[TUNE_W-1:0]};
  endfunction

  assign ctrl_wr   = bus.cfg_wr && (bus.cfg_addr == ADDR_W'(SWEEP_REG_CTRL));
  assign mode      = decode_mode(reg_mode_q);
  assign step_res  = step_clamp(tune_q, step_q, tgt_q, dir_q);
  assign dwell_eff = (reg_dwell_q == '0) ? DWELL_W'(1) : reg_dwell_q;
  // A CTRL write in the same cycle swallows the tick.
  assign tmr_en    = (state_q == S_DWELL) && bus.tick && !ctrl_wr;

  sweep_dwell_timer #(.W(DWELL_W)) u_dwell_timer (
    .clk      (sys_clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick_en  (tmr_en),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    reg_start_d = reg_start_q; reg_stop_d = reg_stop_q; reg_step_d = reg_step_q;
    reg_dwell_d = reg_dwell_q; reg_mode_d = reg_mode_q;
    tune_d = tune_q; tune_valid_d = 1'b0;
    tgt_d = tgt_q; step_d = step_q; dwell_d = dwell_q; dir_d = dir_q;
`ifdef DDS_SWEEP_PINGPONG_EN
    org_d = org_q;
`endif
    tmr_load = 1'b0;
    tmr_val  = dwell_q;

    if (bus.cfg_wr) begin
      case (bus.cfg_addr)
        ADDR_W'(SWEEP_REG_START): reg_start_d = bus.cfg_data;
        ADDR_W'(SWEEP_REG_STOP):  reg_stop_d  = bus.cfg_data;
        ADDR_W'(SWEEP_REG_STEP):  reg_step_d  = bus.cfg_data;
        ADDR_W'(SWEEP_REG_DWELL): reg_dwell_d = DWELL_W'(bus.cfg_data);
        ADDR_W'(SWEEP_REG_CTRL):  reg_mode_d  = bus.cfg_data[2:1];
        default: ;
      endcase
    end

    if (ctrl_wr) begin
      state_d = bus.cfg_data[0] ? S_LOAD : S_IDLE;
    end else begin
      case (state_q)
        S_LOAD: begin
          tune_d       = reg_start_q;
          tune_valid_d = 1'b1;
          dir_d        = (reg_stop_q >= reg_start_q);
          tgt_d        = reg_stop_q;
          step_d       = reg_step_q;
          dwell_d      = dwell_eff;
`ifdef DDS_SWEEP_PINGPONG_EN
          org_d        = reg_start_q;
`endif
          tmr_load     = 1'b1;
          tmr_val      = dwell_eff;
          state_d      = (reg_step_q == '0 || reg_start_q == reg_stop_q) ? S_DONE : S_DWELL;
        end
        S_DWELL: if (tmr_expire) state_d = S_STEP;
        S_STEP: begin
          tune_d       = step_res[TUNE_W-1:0];
          tune_valid_d = 1'b1;
          tmr_load     = 1'b1;
          state_d      = S_DWELL;
          if (step_res[TUNE_W]) begin
            if (mode == SWEEP_REPEAT) state_d = S_LOAD;
`ifdef DDS_SWEEP_PINGPONG_EN
            else if (mode == SWEEP_PINGPONG) begin
              dir_d = ~dir_q;
              org_d = tgt_q;
              tgt_d = org_q;
            end
`endif
            else state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: ;
      endcase
    end

    busy_d = (state_d == S_LOAD) || (state_d == S_DWELL) || (state_d == S_STEP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      reg_start_q  <= '0;
      reg_stop_q   <= '0;
      reg_step_q   <= '0;
      reg_dwell_q  <= '0;
      reg_mode_q   <= '0;
      tune_q       <= '0;
      tune_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      reg_start_q  <= reg_start_d;
      reg_stop_q   <= reg_stop_d;
      reg_step_q   <= reg_step_d;
      reg_dwell_q  <= reg_dwell_d;
      reg_mode_q   <= reg_mode_d;
      tune_q       <= tune_d;
      tune_valid_q <= tune_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Working copies only matter once LOAD has filled them.
  always_ff @(posedge sys_clk) begin
    tgt_q   <= tgt_d;
    step_q  <= step_d;
    dwell_q <= dwell_d;
    dir_q   <= dir_d;
`ifdef DDS_SWEEP_PINGPONG_EN
    org_q   <= org_d;
`endif
  end

  assign bus.tune_out   = tune_q;
  assign bus.tune_valid = tune_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_dds_sweep_sequencer.sv
// Directed and randomized checks of dds_sweep_sequencer against a tick-level sweep model.
module tb_dds_sweep_sequencer;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   obs_q[$];
  int   done_cnt = 0;
  int   exp_q[$];
  int   exp_done;
  int   obs_base;
  int   done_base;

  dds_sweep_sequencer_if #(.TUNE_W(16), .ADDR_W(3)) bus ();

  dds_sweep_sequencer dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tune_valid) obs_q.push_back(int'(bus.tune_out));
    if (bus.done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    bus.cfg_wr   = 1'b1;
    bus.cfg_addr = a[2:0];
    bus.cfg_data = d[15:0];
    cyc();
    bus.cfg_wr   = 1'b0;
  endtask

  task automatic program_regs(input int s, input int e, input int st, input int d);
    wr(0, s); wr(1, e); wr(2, st); wr(3, d);
  endtask

  // One tick, then two cycles (new word visible), then one spare cycle.
  task automatic tick1();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    cyc();
    cyc();
  endtask

  function automatic int eff_mode(input int m);
    if (m == 1) return 1;
`ifdef DDS_SWEEP_PINGPONG_EN
    if (m == 2) return 2;
`endif
    return 0;
  endfunction

  // Expected emitted words for n ticks, written from the sweep rules directly.
  task automatic build_model(input int s, input int e, input int st, input int d,
                             input int m, input int n);
    int org, tgt, cur, nxt, deff, c, md;
    bit hit;
    exp_q.delete();
    exp_done = 0;
    exp_q.push_back(s);
    if (st == 0 || s == e) begin
      exp_done = 1;
      return;
    end
    md = eff_mode(m);
    org = s; tgt = e; cur = s; c = 0;
    deff = (d == 0) ? 1 : d;
    for (int t = 1; t <= n; t++) begin
      c++;
      if (c == deff) begin
        c = 0;
        if (tgt >= org) begin nxt = cur + st; hit = (nxt >= tgt); end
        else            begin nxt = cur - st; hit = (nxt <= tgt); end
        cur = hit ? tgt : nxt;
        exp_q.push_back(cur);
        if (hit) begin
          if (md == 1) begin
            cur = s;
            exp_q.push_back(s);
          end else if (md == 2) begin
            nxt = org; org = tgt; tgt = nxt;
          end else begin
            exp_done = 1;
            return;
          end
        end
      end
    end
  endtask

  task automatic sweep(input string tag, input int s, input int e, input int st,
                       input int d, input int m, input int n);
    int got;
    program_regs(s, e, st, d);
    obs_base  = obs_q.size();
    done_base = done_cnt;
    wr(4, (m << 1) | 1);
    cyc();
    repeat (n) tick1();
    cyc();
    build_model(s, e, st, d, m, n);
    got = obs_q.size() - obs_base;
    check({tag, "_len"}, got, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got; i++)
      check($sformatf("%s_v%0d", tag, i), obs_q[obs_base + i], exp_q[i]);
    check({tag, "_done"}, done_cnt - done_base, exp_done);
    check({tag, "_busy"}, 32'(bus.busy), (exp_done != 0) ? 0 : 1);
    wr(4, m << 1);
    cyc();
  endtask

  initial begin
    int s, e, st, d, m;
    rst = 1'b1;
    bus.tick = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    repeat (3) cyc();
    check("rst_tune", 32'(bus.tune_out), 0);
    check("rst_valid", 32'(bus.tune_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    rst = 1'b0;
    cyc();

    // Single up with per-tick timing
    program_regs(32'h1000, 32'h1040, 32'h10, 2);
    obs_base = obs_q.size();
    done_base = done_cnt;
    wr(4, 1);
    check("go_n_valid", 32'(bus.tune_valid), 0);
    check("go_n_busy", 32'(bus.busy), 1);
    cyc();
    check("go_n2_valid", 32'(bus.tune_valid), 1);
    check("go_n2_tune", 32'(bus.tune_out), 32'h1000);
    cyc();
    for (int t = 1; t <= 8; t++) begin
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
      cyc();
      check($sformatf("up_t%0d_valid", t), 32'(bus.tune_valid), (t % 2 == 0) ? 1 : 0);
      if (t % 2 == 0) check($sformatf("up_t%0d_tune", t), 32'(bus.tune_out), 32'h1000 + 16 * (t / 2));
      cyc();
    end
    check("up_busy_end", 32'(bus.busy), 0);
    check("up_done_cnt", done_cnt - done_base, 1);
    check("up_hold", 32'(bus.tune_out), 32'h1040);
    check("up_count", obs_q.size() - obs_base, 5);

    sweep("clamp_dn", 32'h0010, 32'h0000, 32'h30, 1, 0, 3);
    sweep("clamp_top", 32'hFFF0, 32'hFFFF, 32'h20, 1, 0, 3);
    sweep("pingpong", 0, 32'h20, 32'h10, 1, 2, 6);
    sweep("repeat", 32'h1000, 32'h1030, 32'h10, 1, 1, 9);
    sweep("step0", 32'h0100, 32'h0200, 0, 1, 1, 2);

    // Abort mid-sweep, then restart
    program_regs(32'h1000, 32'h1040, 32'h10, 1);
    wr(4, 1);
    cyc();
    tick1();
    tick1();
    done_base = done_cnt;
    wr(4, 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_tune", 32'(bus.tune_out), 32'h1020);
    repeat (3) cyc();
    check("abort_nodone", done_cnt - done_base, 0);
    check("abort_hold", 32'(bus.tune_out), 32'h1020);
    wr(4, 1);
    check("restart_n_valid", 32'(bus.tune_valid), 0);
    cyc();
    check("restart_valid", 32'(bus.tune_valid), 1);
    check("restart_tune", 32'(bus.tune_out), 32'h1000);
    wr(4, 0);

    // CTRL write coincident with the final dwell tick
    program_regs(32'h1000, 32'h1040, 32'h10, 2);
    wr(4, 1);
    cyc();
    tick1();
    obs_base = obs_q.size();
    bus.tick = 1'b1; bus.cfg_wr = 1'b1; bus.cfg_addr = 3'd4; bus.cfg_data = 16'h0001;
    cyc();
    bus.tick = 1'b0; bus.cfg_wr = 1'b0;
    cyc();
    check("prio_valid", 32'(bus.tune_valid), 1);
    check("prio_tune", 32'(bus.tune_out), 32'h1000);
    cyc();
    check("prio_count", obs_q.size() - obs_base, 1);
    tick1();
    tick1();
    check("prio_next", 32'(bus.tune_out), 32'h1010);
    wr(4, 0);

    // Config write to START alongside a tick: both take effect
    program_regs(32'h1000, 32'h1040, 32'h10, 1);
    wr(4, 1);
    cyc();
    bus.tick = 1'b1; bus.cfg_wr = 1'b1; bus.cfg_addr = 3'd0; bus.cfg_data = 16'h2000;
    cyc();
    bus.tick = 1'b0; bus.cfg_wr = 1'b0;
    cyc();
    check("cotick_valid", 32'(bus.tune_valid), 1);
    check("cotick_tune", 32'(bus.tune_out), 32'h1010);
    cyc();
    wr(5, 32'h3333);
    wr(4, 1);
    cyc();
    check("cotick_start", 32'(bus.tune_out), 32'h2000);
    wr(4, 0);

    // Reset mid-sweep
    program_regs(32'h1000, 32'h1040, 32'h10, 1);
    wr(4, 1);
    cyc();
    tick1();
    rst = 1'b1;
    cyc();
    check("mrst_tune", 32'(bus.tune_out), 0);
    check("mrst_valid", 32'(bus.tune_valid), 0);
    check("mrst_busy", 32'(bus.busy), 0);
    check("mrst_done", 32'(bus.done), 0);
    rst = 1'b0;
    wr(4, 1);
    cyc();
    check("mrst_go_valid", 32'(bus.tune_valid), 1);
    check("mrst_go_tune", 32'(bus.tune_out), 0);
    check("mrst_go_done", 32'(bus.done), 1);
    check("mrst_go_busy", 32'(bus.busy), 0);
    repeat (2) cyc();

    for (int i = 0; i < 8; i++) begin
      s = int'($urandom_range(0, 32'hFFFF));
      e = ($urandom_range(0, 1) == 1) ? s + int'($urandom_range(0, 32'h300))
                                      : s - int'($urandom_range(0, 32'h300));
      if (e < 0) e = 0;
      if (e > 32'hFFFF) e = 32'hFFFF;
      st = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 32'h80));
      d  = int'($urandom_range(0, 3));
      m  = int'($urandom_range(0, 3));
      sweep($sformatf("rnd%0d", i), s, e, st, d, m, 24);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
